// File: rtl/reg_block_v2.sv
// ============================================================================
// reg_block_v2 : register file with reserve/busy tracking, write bypass,
//                immediate operand mux and a self-clearing start-up sequence.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module reg_block_v2 #(
  parameter int DWIDTH   = 32,
  parameter int RWIDTH   = 6,
  parameter int IMM_IN   = 15,
  parameter int SIGN_EXT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RWIDTH-1:0] rs,
  input  logic [RWIDTH-1:0] rt,
  input  logic [RWIDTH-1:0] rd,
  input  logic [DWIDTH-1:0] wd,
  input  logic              we,
  input  logic              res_en,
  input  logic [RWIDTH-1:0] res_addr,
  input  logic              clr_start,
  input  logic              mux_sel,
  input  logic [IMM_IN-1:0] imm_in,
  output logic [DWIDTH-1:0] opA,
  output logic [DWIDTH-1:0] opB,
  output logic [DWIDTH-1:0] opBwd,
  output logic              opA_busy,
  output logic              opB_busy,
  output logic              ready
);

  localparam int DEPTH = 2**RWIDTH;
  localparam bit SEXT  = (SIGN_EXT != 0);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [RWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DWIDTH-1:0]   regs_q [DEPTH];

  logic [DWIDTH-1:0]   opA_q, opA_d;
  logic [DWIDTH-1:0]   opB_q, opB_d;
  logic [DWIDTH-1:0]   opBwd_q, opBwd_d;
  logic                opA_busy_q, opA_busy_d;
  logic                opB_busy_q, opB_busy_d;

  logic                wr_en;
  logic                rsv_en;
  logic [DWIDTH-1:0]   imm_ext;
  logic [DWIDTH-1:0]   rs_data;
  logic [DWIDTH-1:0]   rt_data;

  assign wr_en   = (state_q == IDLE) && we && (rd != '0);
  assign rsv_en  = (state_q == IDLE) && res_en && (res_addr != '0);
  assign imm_ext = {{(DWIDTH-IMM_IN){SEXT & imm_in[IMM_IN-1]}}, imm_in};

  // Same-cycle write is forwarded so a dependent read never sees stale data.
  assign rs_data = (wr_en && (rd == rs)) ? wd : ((rs == '0) ? '0 : regs_q[rs]);
  assign rt_data = (wr_en && (rd == rt)) ? wd : ((rt == '0) ? '0 : regs_q[rt]);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    busy_d     = busy_q;
    opA_d      = '0;
    opB_d      = '0;
    opBwd_d    = '0;
    opA_busy_d = 1'b0;
    opB_busy_d = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_d[clr_cnt_q] = 1'b0;
        clr_cnt_d         = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {RWIDTH{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (wr_en)  busy_d[rd]       = 1'b0;
        // Reserve is applied after the write so it wins on an address clash.
        if (rsv_en) busy_d[res_addr] = 1'b1;
        busy_d[0]  = 1'b0;
        opA_d      = rs_data;
        opBwd_d    = rt_data;
        opB_d      = mux_sel ? imm_ext : rt_data;
        opA_busy_d = busy_d[rs];
        opB_busy_d = !mux_sel && busy_d[rt];
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      opBwd_q    <= '0;
      opA_busy_q <= 1'b0;
      opB_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opBwd_q    <= opBwd_d;
      opA_busy_q <= opA_busy_d;
      opB_busy_q <= opB_busy_d;
    end
  end

  // Storage has no reset; the CLEAR walk zeroes it after reset release.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) regs_q[clr_cnt_q] <= '0;
    else if (wr_en)       regs_q[rd]        <= wd;
  end

  assign opA      = opA_q;
  assign opB      = opB_q;
  assign opBwd    = opBwd_q;
  assign opA_busy = opA_busy_q;
  assign opB_busy = opB_busy_q;
  assign ready    = (state_q == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_reg_block_v2.sv
// ============================================================================
// tb_reg_block_v2 : table-driven, scoreboard-checked bench for reg_block_v2.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_reg_block_v2;

  localparam int DW    = 32;
  localparam int RW    = 6;
  localparam int IW    = 15;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] wd;
    logic          we;
    logic          res_en;
    logic [RW-1:0] res_addr;
    logic          mux_sel;
    logic [IW-1:0] imm;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic [DW-1:0] e_bwd;
    logic          e_ab;
    logic          e_bb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] rs, rt, rd, res_addr;
  logic [DW-1:0] wd;
  logic          we, res_en, clr_start, mux_sel;
  logic [IW-1:0] imm_in;
  logic [DW-1:0] opA, opB, opBwd;
  logic          opA_busy, opB_busy, ready;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t exp_q[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  reg_block_v2 #(.DWIDTH(DW), .RWIDTH(RW), .IMM_IN(IW), .SIGN_EXT(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd), .wd(wd), .we(we),
    .res_en(res_en), .res_addr(res_addr), .clr_start(clr_start),
    .mux_sel(mux_sel), .imm_in(imm_in), .opA(opA), .opB(opB), .opBwd(opBwd),
    .opA_busy(opA_busy), .opB_busy(opB_busy), .ready(ready)
  );

  task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [RW-1:0] a_rs, a_rt, a_rd, input logic [DW-1:0] a_wd,
                              input logic a_we, a_res, input logic [RW-1:0] a_ra,
                              input logic a_mux, input logic [IW-1:0] a_imm,
                              input logic [DW-1:0] ea, eb, ebwd, input logic eab, ebb);
    vec_t v;
    v.rs = a_rs; v.rt = a_rt; v.rd = a_rd; v.wd = a_wd; v.we = a_we;
    v.res_en = a_res; v.res_addr = a_ra; v.mux_sel = a_mux; v.imm = a_imm;
    v.e_a = ea; v.e_b = eb; v.e_bwd = ebwd; v.e_ab = eab; v.e_bb = ebb;
    return v;
  endfunction

  task automatic drive_idle();
    rs = '0; rt = '0; rd = '0; wd = '0; we = 1'b0; res_en = 1'b0;
    res_addr = '0; clr_start = 1'b0; mux_sel = 1'b0; imm_in = '0;
  endtask

  task automatic score(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk1({tag, " scoreboard empty"}, 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    chk32({tag, " opA"},      opA,      e.e_a);
    chk32({tag, " opB"},      opB,      e.e_b);
    chk32({tag, " opBwd"},    opBwd,    e.e_bwd);
    chk1 ({tag, " opA_busy"}, opA_busy, e.e_ab);
    chk1 ({tag, " opB_busy"}, opB_busy, e.e_bb);
  endtask

  task automatic apply(input vec_t v, input logic clr, input string tag);
    @(negedge clk);
    rs = v.rs; rt = v.rt; rd = v.rd; wd = v.wd; we = v.we; res_en = v.res_en;
    res_addr = v.res_addr; mux_sel = v.mux_sel; imm_in = v.imm; clr_start = clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1 score(tag);
  endtask

  // Counts rising edges until ready is seen high; optionally pokes writes/reserves mid-clear.
  task automatic count_clear(input bit inject, output int n);
    n = 0;
    do begin
      @(negedge clk);
      drive_idle();
      if (inject && n == 30) begin
        we = 1'b1; rd = 6'd3; wd = 32'h0000_0055;
        res_en = 1'b1; res_addr = 6'd4; rs = 6'd63; rt = 6'd63; clr_start = 1'b1;
      end
      @(posedge clk);
      n++;
      #1;
      if (inject && n == 31) begin
        chk32("clear-phase opA", opA, '0);
        chk1 ("clear-phase ready", ready, 1'b0);
      end
    end while (!ready && n < 200);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic scan_zero(input string tag);
    for (int i = 0; i < DEPTH; i++)
      apply(mk(RW'(i), RW'(i), '0, '0, 0, 0, '0, 0, '0, '0, '0, '0, 0, 0), 1'b0, tag);
  endtask

  initial begin
    int n;
    tbl[0]  = mk(63, 0, 63, 32'hFFAAFFAA, 1, 0, 0, 0, 0, 32'hFFAAFFAA, 0, 0, 0, 0);
    tbl[1]  = mk(63, 63, 0, 0, 0, 0, 0, 0, 0, 32'hFFAAFFAA, 32'hFFAAFFAA, 32'hFFAAFFAA, 0, 0);
    tbl[2]  = mk(0, 0, 0, 32'hAAAAAAAA, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(12, 12, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(12, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(12, 12, 12, 32'hAAAAAAAA, 1, 0, 0, 0, 0, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 0);
    tbl[7]  = mk(12, 63, 12, 32'h12345678, 1, 1, 12, 0, 0, 32'h12345678, 32'hFFAAFFAA, 32'hFFAAFFAA, 1, 0);
    tbl[8]  = mk(12, 12, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 32'h12345678, 1, 1);
    tbl[9]  = mk(63, 12, 0, 0, 0, 0, 0, 1, 15'h4000, 32'hFFAAFFAA, 32'hFFFFC000, 32'h12345678, 0, 0);
    tbl[10] = mk(63, 63, 0, 0, 0, 0, 0, 1, 15'h1FFF, 32'hFFAAFFAA, 32'h00001FFF, 32'hFFAAFFAA, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(12, 7, 7, 32'h0BADF00D, 1, 0, 0, 0, 0, 32'h12345678, 32'h0BADF00D, 32'h0BADF00D, 1, 0);
    tbl[13] = mk(12, 12, 0, 0, 0, 0, 0, 1, 15'h7FFF, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1, 0);

    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk1 ("reset ready",    ready,    1'b0);
    chk32("reset opA",      opA,      '0);
    chk32("reset opB",      opB,      '0);
    chk32("reset opBwd",    opBwd,    '0);
    chk1 ("reset opA_busy", opA_busy, 1'b0);
    chk1 ("reset opB_busy", opB_busy, 1'b0);
    #1 rst_n = 1'b1;
    count_clear(1'b0, n);
    chk32("startup clear length", 32'(n), 32'd64);
    scan_zero("post-reset scan");

    for (int i = 0; i < 14; i++) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // clr_start together with a write: the write lands and bypasses, then CLEAR wipes it.
    apply(mk(20, 12, 20, 32'hDEADBEEF, 1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 0, 1),
          1'b1, "clr+write");
    count_clear(1'b1, n);
    chk32("clr_start clear length", 32'(n), 32'd64);
    apply(mk(20, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "after clr r20/r3");
    apply(mk(12, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "after clr r12/r4");
    apply(mk(63, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "after clr r63/r7");

    // Dirty the file again, start a clear and hit it with reset at CLEAR cycle 10.
    apply(mk(12, 63, 63, 32'h00001111, 1, 1, 12, 0, 0, 0, 32'h00001111, 32'h00001111, 1, 0),
          1'b0, "pre-clear dirty");
    apply(mk(12, 63, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00001111, 32'h00001111, 1, 0), 1'b1, "clr_start");
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1 ("mid-clear reset ready", ready, 1'b0);
    chk32("mid-clear reset opA",   opA,   '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    count_clear(1'b0, n);
    chk32("restarted clear length", 32'(n), 32'd64);
    scan_zero("post-restart scan");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_block_v2.md
REG_BLOCK_V2 -- requirements
Module: reg_block_v2

Interface
REQ-001 Parameter DWIDTH, default 32, data width of each register and operand.
REQ-002 Parameter RWIDTH, default 6, register address width; DEPTH = 2**RWIDTH registers.
REQ-003 Parameter IMM_IN, default 15, immediate input width, with IMM_IN < DWIDTH.
REQ-004 Parameter SIGN_EXT, default 1, where 1 sign-extends imm_in and 0 zero-extends it.
REQ-005 clk  in  1  single clock, with all state updated on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rs  in  RWIDTH  read address A.
REQ-008 rt  in  RWIDTH  read address B.
REQ-009 rd  in  RWIDTH  write address.
REQ-010 wd  in  DWIDTH  write data.
REQ-011 we  in  1  write enable.
REQ-012 res_en  in  1  reserve request, marking res_addr as pending-write.
REQ-013 res_addr  in  RWIDTH  register to reserve.
REQ-014 clr_start  in  1  request to restart the full-file clear sequence.
REQ-015 mux_sel  in  1  operand-B source select, where 1 selects the extended immediate and 0 selects the register.
REQ-016 imm_in  in  IMM_IN  immediate value.
REQ-017 opA  out  DWIDTH  registered read of rs.
REQ-018 opB  out  DWIDTH  registered operand B, either the register or the immediate.
REQ-019 opBwd  out  DWIDTH  registered raw read of rt, used as store data regardless of mux_sel.
REQ-020 opA_busy  out  1  registered flag: rs was pending-write at sample time.
REQ-021 opB_busy  out  1  registered flag: rt was pending-write at sample time, forced to 0 when mux_sel=1.
REQ-022 ready  out  1  high in IDLE state, low while clearing.

Function
REQ-023 The FSM SHALL have two states, CLEAR and IDLE, with a clear counter clr_cnt of RWIDTH bits.
REQ-024 In CLEAR, each cycle SHALL write 0 to regs[clr_cnt] and clear busy[clr_cnt], then increment clr_cnt.
REQ-025 The FSM SHALL move from CLEAR to IDLE on the cycle in which clr_cnt = DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
REQ-026 In IDLE, clr_start=1 SHALL return the FSM to CLEAR with clr_cnt=0 on the next edge.
REQ-027 In CLEAR, clr_start SHALL be ignored.
REQ-028 In CLEAR, we and res_en SHALL be ignored, and opA, opB, opBwd, opA_busy and opB_busy SHALL be loaded with 0.
REQ-029 In IDLE, a rising edge with we=1 and rd!=0 SHALL write wd into regs[rd] and clear busy[rd].
REQ-030 Register 0 SHALL always read 0, SHALL ignore writes and reserves, and busy[0] SHALL always be 0.
REQ-031 In IDLE, res_en=1 with res_addr!=0 SHALL set busy[res_addr].
REQ-032 If res_en and we target the same address in the same cycle, the reserve SHALL win: data is written and busy ends at 1.
REQ-033 Read latency SHALL be 1 cycle: outputs sampled at edge N reflect rs, rt, mux_sel and imm_in presented before edge N.
REQ-034 Write-to-read bypass: if we=1, rd!=0 and rd equals rs (or rt) in the same cycle, opA (or the rt read) SHALL take wd, not the stale regs[] value.
REQ-035 opA_busy SHALL equal busy[rs] after that cycle's write and reserve updates; the same rule SHALL apply to opB_busy with rt.
REQ-036 For the extended immediate, bits [IMM_IN-1:0] SHALL be imm_in, and the upper bits SHALL be imm_in[IMM_IN-1] when SIGN_EXT=1, else 0.
REQ-037 When mux_sel=1, opB SHALL be the extended immediate; otherwise opB SHALL equal opBwd.
REQ-038 clr_start=1 in the same IDLE cycle as we=1 SHALL let the write occur, with CLEAR then overwriting it.

Reset
REQ-039 On rst_n=0, asynchronously: FSM to CLEAR, clr_cnt to 0, all busy bits to 0, and opA, opB, opBwd, opA_busy, opB_busy and ready to 0.
REQ-040 The register array SHALL NOT be asynchronously reset; it SHALL be zeroed by the CLEAR sequence after rst_n rises.
REQ-041 rst_n asserted mid-CLEAR SHALL restart the sequence from clr_cnt=0.

Verification
REQ-042 Release rst_n -> ready=0 for exactly 64 cycles (RWIDTH=6), then 1; read of every address -> opA=0.
REQ-043 IDLE, we=1, rd=63, wd=FFAAFFAA, rs=63 in the same cycle -> next edge opA=FFAAFFAA (bypass); a later read of rs=63 -> FFAAFFAA.
REQ-044 we=1, rd=0, wd=AAAAAAAA, then rs=0 -> opA=0 and opA_busy=0.
REQ-045 res_en=1, res_addr=12; next cycle rs=12 -> opA_busy=1; we=1, rd=12, wd=AAAAAAAA with rs=12 -> opA=AAAAAAAA, opA_busy=0; res_en and we both to 12 -> busy stays 1.
REQ-046 mux_sel=1, imm_in=15'h4000, SIGN_EXT=1 -> opB=FFFFC000; imm_in=15'h1FFF -> opB=00001FFF; opBwd holds regs[rt] and opB_busy=0.
REQ-047 clr_start=1 in IDLE, with rst_n pulsed low at CLEAR cycle 10 -> ready low for 64 cycles after release; all registers 0 and all busy bits 0 afterward.
